fpalu_stim_seq: RTL and testbench
=================================

Name: fpalu_stim_seq

Overview:
Synthesizable, parametrised stimulus sequencer and result compactor for FPALU built-in self-test.
- Generates pseudo-random operand pairs from two LFSRs and formats them into FPALU unified fields.
- Runs an ADD phase, then a MUL phase, with per-phase vector counts.
- Compacts latency-aligned FPALU results into a MISR signature.
- Sits beside FPALU in the FPU as a replacement for a behavioural random-stimulus bench.

Parameters:
EXP_W, 6, exponent field width
MAN_W, 22, mantissa field width (denormal-capable)
LFSR_W, 32, operand LFSR width; must be >= EXP_W+MAN_W+1
N_ADD, 200, vectors issued in ADD phase (0 skips the phase)
N_MUL, 200, vectors issued in MUL phase (0 skips the phase)
PIPE_LAT, 2, FPALU input-to-output latency in cycles, >= 1
SEED_A, 32'h1234_5678, LFSR A seed; a zero value is replaced by 1
SEED_B, 32'h8765_4321, LFSR B seed; a zero value is replaced by 1
GOLDEN_SIG, 32'h0, expected signature (optional feature only)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  start pulse; sampled only in IDLE or DONE
abort  in  1  synchronous abort
opcode  out  2  2'b11 ADD, 2'b10 MUL, 2'b00 idle
a_sgn / b_sgn  out  1  operand signs
a_exp / b_exp  out  EXP_W  operand exponents
a_man_dn / b_man_dn  out  MAN_W  operand mantissas
y_sgn  in  1  FPALU result sign
y_exp  in  EXP_W  FPALU result exponent
y_man_dn  in  MAN_W  FPALU result mantissa
busy  out  1  high from first issue until done
done  out  1  level; held until next start or abort
sig  out  32  MISR signature
pass  out  1  signature matches GOLDEN_SIG

Behaviour:
- Reset (async, rst_n low): state IDLE; all outputs 0; LFSRs hold seeds; tag pipe cleared.
- States and transitions:
  - IDLE -> ADD on start. Go to MUL instead if N_ADD=0; go to DRAIN if both counts are 0.
  - ADD -> MUL after N_ADD issues (DRAIN if N_MUL=0).
  - MUL -> DRAIN after N_MUL issues.
  - DRAIN -> DONE once the tag pipe is empty.
  - DONE -> ADD/MUL/DRAIN on start, same rules as IDLE.
- Start edge: reload both LFSRs from seeds, clear sig to 0, clear vector counter. First vector appears in the cycle after the start edge.
- Issue: one vector per cycle, back-to-back, with no bubble at the phase change. Both LFSRs step once per issue. The vector i operand is the LFSR state after i steps; vector 0 is the seed.
- LFSR: Galois, polynomial x^32+x^22+x^2+x+1.
- Formatting, with A/B as the LFSR values:
  - a_sgn = A[EXP_W+MAN_W]
  - a_exp = {1'b1, A[EXP_W+MAN_W-2:MAN_W]}
  - b_sgn = B[EXP_W+MAN_W]
  - b_exp = B[EXP_W+MAN_W-1:MAN_W]
  - MUL phase: man = raw [MAN_W-1:0]
  - ADD phase: man = {1'b1, [MAN_W-2:0]} (forced normal)
- Outside issue cycles: opcode=2'b00 and all operand fields are 0.
- Tag pipe: PIPE_LAT-deep valid shift register. A result is captured on the edge closing cycle t+PIPE_LAT for a vector issued in cycle t.
- MISR update on capture: sig <= step(sig) XOR zero-extended {y_sgn, y_exp, y_man_dn}, using the same polynomial.
- busy falls and done rises on the same edge, after the final capture.
- abort: any state -> IDLE next edge; busy=0, done=0, opcode=00, tag pipe cleared, sig frozen. abort wins over a simultaneous start.
- start while in ADD/MUL/DRAIN: ignored.

Optional Feature:
FPALU_STIM_GOLDEN_EN
- Defined: pass = done & (sig == GOLDEN_SIG), registered, reset 0, cleared on start and abort.
- Undefined: pass tied 0 and no comparator is built.

Test Plan:
1. N_ADD=4, N_MUL=3, PIPE_LAT=2, start at edge 0 -> opcode 11 in cycles 1-4, 10 in cycles 5-7, 00 from cycle 8; busy cycles 1-9; done=1 from cycle 10.
2. SEED_A=32'h1FFF_FFFF, SEED_B=32'h0000_0001 -> vector 0 a_sgn=1, a_exp=6'h3F, a_man_dn=22'h3FFFFF, b_exp=0, b_man_dn=22'h200001. With N_ADD=0, b_man_dn=22'h000001.
3. FPALU model fed back with PIPE_LAT=2 -> sig bit-exact to the bench MISR model; a second start reproduces the identical sig. With the macro defined and GOLDEN_SIG set to that value -> pass=1.
4. abort in cycle 6 of scenario 1 -> IDLE at cycle 7, busy=0, done=0, sig frozen. Abort asserted together with a start from IDLE -> stays IDLE.
5. rst_n low mid-MUL -> all outputs 0 without waiting for a clock edge. After release, start restarts from the seeds with sig=0.
6. start pulsed during MUL -> no effect on counts. N_ADD=N_MUL=0 with start -> no issue, done=1 after PIPE_LAT+1 cycles, sig=0.

Source files
------------

// File: rtl/fpalu_stim_seq.sv
// fpalu_stim_seq: FPALU BIST stimulus sequencer (LFSR operands, ADD then MUL phase) and MISR result compactor.
// Optional golden-signature comparator enabled by defining FPALU_STIM_GOLDEN_EN.
module fpalu_stim_seq #(
  parameter int EXP_W = 6,
  parameter int MAN_W = 22,
  parameter int LFSR_W = 32,
  parameter int N_ADD = 200,
  parameter int N_MUL = 200,
  parameter int PIPE_LAT = 2,
  parameter logic [31:0] SEED_A = 32'h1234_5678,
  parameter logic [31:0] SEED_B = 32'h8765_4321,
  parameter logic [31:0] GOLDEN_SIG = 32'h0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic abort,
  output logic [1:0] opcode,
  output logic a_sgn,
  output logic [EXP_W-1:0] a_exp,
  output logic [MAN_W-1:0] a_man_dn,
  output logic b_sgn,
  output logic [EXP_W-1:0] b_exp,
  output logic [MAN_W-1:0] b_man_dn,
  input  logic y_sgn,
  input  logic [EXP_W-1:0] y_exp,
  input  logic [MAN_W-1:0] y_man_dn,
  output logic busy,
  output logic done,
  output logic [31:0] sig,
  output logic pass
);
  localparam logic [LFSR_W-1:0] LPOLY = LFSR_W'(32'h8020_0003);
  localparam logic [31:0] SPOLY = 32'h8020_0003;
  localparam logic [LFSR_W-1:0] SA = (SEED_A == 32'h0) ? LFSR_W'(1) : LFSR_W'(SEED_A);
  localparam logic [LFSR_W-1:0] SB = (SEED_B == 32'h0) ? LFSR_W'(1) : LFSR_W'(SEED_B);
  localparam logic [31:0] LA = 32'(N_ADD - 1);
  localparam logic [31:0] LM = 32'(N_MUL - 1);
  localparam logic [31:0] LD = 32'(PIPE_LAT - 1);
  typedef enum logic [2:0] {IDLE, ADD, MUL, DRAIN, DONE} state_t;
  state_t state, state_n, first;
  logic [LFSR_W-1:0] lfsr_a, lfsr_b;
  logic [31:0] cnt;
  logic [PIPE_LAT-1:0] tag;
  logic go, add, mul, issue, cap;
  function automatic logic [LFSR_W-1:0] lstep(input logic [LFSR_W-1:0] s);
    return (s >> 1) ^ (s[0] ? LPOLY : '0);
  endfunction
  function automatic logic [31:0] sstep(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? SPOLY : 32'h0);
  endfunction
  assign first = (N_ADD != 0) ? ADD : (N_MUL != 0) ? MUL : DRAIN;
  assign go = start && (state == IDLE || state == DONE);
  assign add = state == ADD;
  assign mul = state == MUL;
  assign issue = add || mul;
  assign cap = tag[PIPE_LAT-1];
  assign busy = issue || state == DRAIN;
  assign done = state == DONE;
  // next state and combinational operand formatting from the current LFSR values
  always_comb begin
    state_n = abort ? IDLE : go ? first
            : (add && cnt == LA) ? ((N_MUL != 0) ? MUL : DRAIN)
            : (mul && cnt == LM) ? DRAIN
            : (state == DRAIN && cnt == LD) ? DONE : state;
    opcode = add ? 2'b11 : mul ? 2'b10 : 2'b00;
    a_sgn = issue & lfsr_a[EXP_W+MAN_W];
    a_exp = issue ? {1'b1, lfsr_a[EXP_W+MAN_W-2:MAN_W]} : '0;
    a_man_dn = add ? {1'b1, lfsr_a[MAN_W-2:0]} : mul ? lfsr_a[MAN_W-1:0] : '0;
    b_sgn = issue & lfsr_b[EXP_W+MAN_W];
    b_exp = issue ? lfsr_b[EXP_W+MAN_W-1:MAN_W] : '0;
    b_man_dn = add ? {1'b1, lfsr_b[MAN_W-2:0]} : mul ? lfsr_b[MAN_W-1:0] : '0;
  end
  // state, phase counter, operand LFSRs, result-valid tag pipe and MISR
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      lfsr_a <= SA;
      lfsr_b <= SB;
      tag <= '0;
      sig <= '0;
    end else begin
      state <= state_n;
      cnt <= (go || state_n != state) ? '0 : busy ? cnt + 32'd1 : cnt;
      tag <= abort ? '0 : PIPE_LAT'({tag, issue});
      if (!abort && go) begin
        lfsr_a <= SA;
        lfsr_b <= SB;
      end else if (!abort && issue) begin
        lfsr_a <= lstep(lfsr_a);
        lfsr_b <= lstep(lfsr_b);
      end
      if (!abort)
        sig <= go ? '0 : cap ? sstep(sig) ^ 32'({y_sgn, y_exp, y_man_dn}) : sig;
    end
  end
`ifdef FPALU_STIM_GOLDEN_EN
  // registered golden-signature match, valid while done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pass <= 1'b0;
    else pass <= (abort || go) ? 1'b0 : done && sig == GOLDEN_SIG;
  end
`else
  assign pass = 1'b0;
`endif
endmodule

// File: tb/tb_fpalu_stim_seq.sv
// tb_fpalu_stim_seq: scoreboard bench for fpalu_stim_seq with a pipelined FPALU stand-in model.
module tb_fpalu_stim_seq;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic [1:0] opcode, op1, op2;
  logic a_sgn, b_sgn, as1, bs1, as2, bs2;
  logic [5:0] a_exp, b_exp, ae1, be1, ae2, be2;
  logic [21:0] a_man_dn, b_man_dn, am1, bm1, am2, bm2;
  logic y_sgn;
  logic [5:0] y_exp;
  logic [21:0] y_man_dn;
  logic busy, done, pass, busy1, done1, pass1, busy2, done2, pass2;
  logic [31:0] sig, sig1, sig2;
  logic [28:0] p1 = '0, p2 = '0;
  logic [59:0] sb[$];
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  fpalu_stim_seq #(.N_ADD(4), .N_MUL(3), .PIPE_LAT(2), .SEED_A(32'h1FFF_FFFF), .SEED_B(32'h0000_0001)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .opcode(opcode),
    .a_sgn(a_sgn), .a_exp(a_exp), .a_man_dn(a_man_dn), .b_sgn(b_sgn), .b_exp(b_exp), .b_man_dn(b_man_dn),
    .y_sgn(y_sgn), .y_exp(y_exp), .y_man_dn(y_man_dn), .busy(busy), .done(done), .sig(sig), .pass(pass));
  fpalu_stim_seq #(.N_ADD(0), .N_MUL(2), .PIPE_LAT(2), .SEED_A(32'h1FFF_FFFF), .SEED_B(32'h0000_0001)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .opcode(op1),
    .a_sgn(as1), .a_exp(ae1), .a_man_dn(am1), .b_sgn(bs1), .b_exp(be1), .b_man_dn(bm1),
    .y_sgn(1'b0), .y_exp(6'h0), .y_man_dn(22'h0), .busy(busy1), .done(done1), .sig(sig1), .pass(pass1));
  fpalu_stim_seq #(.N_ADD(0), .N_MUL(0), .PIPE_LAT(2)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .opcode(op2),
    .a_sgn(as2), .a_exp(ae2), .a_man_dn(am2), .b_sgn(bs2), .b_exp(be2), .b_man_dn(bm2),
    .y_sgn(1'b1), .y_exp(6'h3F), .y_man_dn(22'h3FFFFF), .busy(busy2), .done(done2), .sig(sig2), .pass(pass2));

  function automatic logic [31:0] lstep(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  function automatic logic [28:0] y_of(input logic [59:0] v);
    logic [5:0] e;
    logic [21:0] m;
    e = v[56:51] + v[27:22];
    m = (v[59:58] == 2'b11) ? v[50:29] + v[21:0] : v[50:29] ^ v[21:0];
    return {v[57] ^ v[28], e, m};
  endfunction

  function automatic logic [59:0] vec(input int i);
    logic [31:0] a, b;
    logic ad;
    a = 32'h1FFF_FFFF;
    b = 32'h0000_0001;
    for (int j = 0; j < i; j++) begin
      a = lstep(a);
      b = lstep(b);
    end
    ad = i < 4;
    return {ad ? 2'b11 : 2'b10, a[28], 1'b1, a[26:22], ad ? {1'b1, a[20:0]} : a[21:0],
            b[28], b[27:22], ad ? {1'b1, b[20:0]} : b[21:0]};
  endfunction

  function automatic logic [31:0] model_sig(input int n);
    logic [31:0] s;
    s = '0;
    for (int i = 0; i < n; i++) s = lstep(s) ^ {3'b0, y_of(vec(i))};
    return s;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  task automatic push(input int n);
    for (int i = 0; i < n; i++) sb.push_back(vec(i));
  endtask

  task automatic do_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // FPALU stand-in: two-cycle pipelined result of the presented operands
  always @(posedge clk) begin
    p1 <= y_of({opcode, a_sgn, a_exp, a_man_dn, b_sgn, b_exp, b_man_dn});
    p2 <= p1;
  end
  assign {y_sgn, y_exp, y_man_dn} = p2;

  // monitor: every issued vector must match the next expected entry
  always @(negedge clk) begin
    if (rst_n && opcode != 2'b00) begin
      if (sb.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL sb_unexpected: got %h expected none", {opcode, a_sgn, a_exp, a_man_dn, b_sgn, b_exp, b_man_dn});
      end else
        chk("sb_vec", {4'h0, opcode, a_sgn, a_exp, a_man_dn, b_sgn, b_exp, b_man_dn}, {4'h0, sb.pop_front()});
    end
  end

  task automatic run_full(input bit pulse, input bit side);
    push(7);
    do_start();
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      chk("opcode", opcode, k <= 4 ? 2'b11 : k <= 7 ? 2'b10 : 2'b00);
      chk("busy", busy, k <= 9);
      chk("done", done, k >= 10);
      if (k == 1) chk("sig_clear", sig, 0);
      if (side && k == 1) begin
        chk("v0_a_sgn", a_sgn, 1);
        chk("v0_a_exp", a_exp, 6'h3F);
        chk("v0_a_man", a_man_dn, 22'h3FFFFF);
        chk("v0_b_exp", b_exp, 6'h00);
        chk("v0_b_man", b_man_dn, 22'h200001);
        chk("mulonly_op", op1, 2'b10);
        chk("mulonly_b_man", bm1, 22'h000001);
        chk("zero_op", op2, 2'b00);
      end
      if (side && k == 2) chk("zero_done_early", done2, 0);
      if (side && k == 3) begin
        chk("zero_done", done2, 1);
        chk("zero_sig", sig2, 0);
      end
      start = pulse && k == 6;
    end
    chk("sig_final", sig, model_sig(7));
    chk("pass_off", pass, 0);
    chk("sb_empty", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    #12;
    chk("rst_opcode", opcode, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sig", sig, 0);
    chk("rst_pass", pass, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_full(1'b0, 1'b1);
    run_full(1'b0, 1'b0);
    push(6);
    do_start();
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k <= 6) chk("ab_opcode", opcode, k <= 4 ? 2'b11 : 2'b10);
      if (k == 6) abort = 1'b1;
      if (k == 7) begin
        chk("ab_busy", busy, 0);
        chk("ab_done", done, 0);
        chk("ab_opcode_idle", opcode, 0);
        chk("ab_sig_frozen", sig, model_sig(3));
        abort = 1'b0;
      end
    end
    @(posedge clk);
    #1 abort = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("abst_busy", busy, 0);
    chk("abst_opcode", opcode, 0);
    chk("abst_done", done, 0);
    chk("abst_sig", sig, model_sig(3));
    chk("ab_sb_empty", sb.size(), 0);
    push(6);
    do_start();
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_opcode", opcode, 0);
    chk("arst_busy", busy, 0);
    chk("arst_sig", sig, 0);
    chk("arst_a_man", a_man_dn, 0);
    chk("arst_b_man", b_man_dn, 0);
    chk("arst_sb_empty", sb.size(), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_full(1'b1, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
